// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Program-counter and instruction-fetch sequencer for the single-cycle RV32
// core. Holds the PC, selects the next PC (sequential / branch / JAL / JALR),
// drives the ROM word address, and provides run / hold / single-step control
// plus halting on end-of-program or a misaligned target.
//
// Optional feature macro: FETCH_SINGLE_STEP_EN
//   defined     : step_btn goes through a 2-FF synchronizer and a rising-edge
//                 detector; step_mode=1 advances only on that step pulse.
//   not defined : step_mode / step_btn are ignored and no synchronizer flops
//                 exist; the core advances on tick only.
//
// Ports:
//   clk          in   system clock
//   rstn         in   synchronous active-low reset
//   tick         in   one-cycle advance pulse from the clock divider
//   hold         in   level, 1 freezes the PC
//   step_mode    in   level, 1 = advance only on the step button
//   step_btn     in   raw asynchronous push-button
//   restart      in   pulse, leaves HALT (no effect in RUN)
//   br_taken     in   conditional branch taken
//   jal          in   JAL in current instruction
//   jalr         in   JALR in current instruction
//   imm          in   sign-extended byte offset for branch / JAL
//   jalr_target  in   rs1+imm from the ALU
//   pc           out  current PC (byte address)
//   pc_plus4     out  pc+4, link value
//   rom_addr     out  ROM word address = pc[ADDR_W+1:2]
//   adv          out  PC commits this cycle (write-enable qualifier)
//   halted       out  state == HALT (also serves as the FSM state view)
//   done         out  halted because of end-of-program
//   err          out  halted because of a misaligned target
//   retired      out  committed-instruction count, saturating at 16'hFFFF
//
// Handshake: there is no valid/ready pair here; adv is the single qualifier.
// Downstream state (RF/DM) may only be written in a cycle where adv=1, and the
// control inputs are only looked at in that same cycle.
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int          ADDR_W    = 6,
   parameter int          INSTR_NUM = 12,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int          WRAP      = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              tick,
   input  logic              hold,
   input  logic              step_mode,
   input  logic              step_btn,
   input  logic              restart,
   input  logic              br_taken,
   input  logic              jal,
   input  logic              jalr,
   input  logic [31:0]       imm,
   input  logic [31:0]       jalr_target,
   output logic [31:0]       pc,
   output logic [31:0]       pc_plus4,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              adv,
   output logic              halted,
   output logic              done,
   output logic              err,
   output logic [15:0]       retired
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   localparam logic [29:0] INSTR_LIM = 30'(INSTR_NUM);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [15:0] retired_q, retired_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        trigger;
   logic [31:0] target;
   logic [31:0] offset;
   logic        misaligned;
   logic        end_of_prog;
   logic [15:0] retired_inc;

   // ---------------------------------------------------------------------------
   // Advance trigger
   // ---------------------------------------------------------------------------
`ifdef FETCH_SINGLE_STEP_EN
   logic step_s1_q, step_s2_q, step_s3_q;
   logic step_pulse;

   // s1/s2 form the synchronizer; s3 remembers the previous synchronized level
   // so a held button yields only one pulse.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         step_s1_q <= 1'b0;
         step_s2_q <= 1'b0;
         step_s3_q <= 1'b0;
      end else begin
         step_s1_q <= step_btn;
         step_s2_q <= step_s1_q;
         step_s3_q <= step_s2_q;
      end
   end

   assign step_pulse = step_s2_q & ~step_s3_q;
   assign trigger    = step_mode ? step_pulse : tick;
`else
   logic unused_step;
   assign unused_step = step_mode ^ step_btn;
   assign trigger     = tick;
`endif

   // Selecting one trigger source means tick and step in the same cycle can
   // only ever give a single advance; hold simply masks it (nothing is queued).
   assign adv = (state_q == RUN) & ~hold & trigger;

   // ---------------------------------------------------------------------------
   // Next-PC selection: jalr > jal > br_taken > sequential
   // ---------------------------------------------------------------------------
   always_comb begin
      target = pc_q + 32'd4;
      if (jalr) begin
         target = {jalr_target[31:1], 1'b0};
      end else if (jal || br_taken) begin
         target = pc_q + imm;
      end
   end

   assign misaligned  = target[1];
   // Word index is taken relative to RESET_PC so the program window is
   // RESET_PC .. RESET_PC + 4*INSTR_NUM - 1.
   assign offset      = target - RESET_PC;
   assign end_of_prog = (target < RESET_PC) || (offset[31:2] >= INSTR_LIM);
   assign retired_inc = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;

   // ---------------------------------------------------------------------------
   // FSM: next state and datapath updates
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      retired_d = retired_q;
      done_d    = done_q;
      err_d     = err_q;
      case (state_q)
         RUN: begin
            if (adv) begin
               // Misalignment wins over end-of-program; the faulting
               // instruction is not counted as retired.
               if (misaligned) begin
                  state_d = HALT;
                  err_d   = 1'b1;
               end else if (end_of_prog) begin
                  retired_d = retired_inc;
                  if (WRAP != 0) begin
                     pc_d = RESET_PC;
                  end else begin
                     state_d = HALT;
                     done_d  = 1'b1;
                  end
               end else begin
                  pc_d      = target;
                  retired_d = retired_inc;
               end
            end
         end
         HALT: begin
            if (restart) begin
               state_d   = RUN;
               pc_d      = RESET_PC;
               retired_d = 16'd0;
               done_d    = 1'b0;
               err_d     = 1'b0;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         retired_q <= 16'd0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         retired_q <= retired_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign pc       = pc_q;
   assign pc_plus4 = pc_q + 32'd4;
   assign rom_addr = pc_q[ADDR_W+1:2];
   assign halted   = (state_q == HALT);
   assign done     = done_q;
   assign err      = err_q;
   assign retired  = retired_q;

endmodule
